apb3_master: RTL and testbench

//  APB3 initiator: converts a valid/ready command stream into single APB3 transfers
//  (SETUP then ACCESS) and returns read data/error on a valid/ready response stream.

---
 rtl/apb3_master_if.sv | 41 ++++
 rtl/apb3_master.sv | 153 +++++++++++++++
 tb/tb_apb3_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_master_if.sv
// Command/response streams plus the APB3 bus of one initiator.
// master: the initiator's view; slave: the requester + APB target's view.
interface apb3_master_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  logic [AW-1:0] m_apb3_paddr;
  logic          m_apb3_psel;
  logic          m_apb3_penable;
  logic          m_apb3_pwrite;
  logic [DW-1:0] m_apb3_pwdata;
  logic          m_apb3_pready;
  logic [DW-1:0] m_apb3_prdata;
  logic          m_apb3_pslverror;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  m_apb3_pready, m_apb3_prdata, m_apb3_pslverror,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output m_apb3_paddr, m_apb3_psel, m_apb3_penable, m_apb3_pwrite, m_apb3_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output m_apb3_pready, m_apb3_prdata, m_apb3_pslverror,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  m_apb3_paddr, m_apb3_psel, m_apb3_penable, m_apb3_pwrite, m_apb3_pwdata
  );
endinterface

// File: rtl/apb3_master.sv
// APB3 initiator: one command -> SETUP+ACCESS transfer -> one response; APB3_MASTER_TIMEOUT_EN adds ACCESS abort.
// Latency: accept T -> psel T+1, penable T+2, rsp_valid one cycle after pready.
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready, single outstanding transfer.
module apb3_master #(
  parameter int APB_AW         = 20,
  parameter int APB_DW         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  apb3_master_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  rsp_t   rsp_q, rsp_nxt;
  logic   psel_q, psel_nxt;
  logic   penable_q, penable_nxt;
  logic   rsp_valid_q, rsp_valid_nxt;
  logic   tmo_hit;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;

  // Fires on the ACCESS cycle whose increment would reach the limit; pready on that cycle still wins.
  assign tmo_hit = (state == ACCESS) && !bus.m_apb3_pready &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  wire unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef APB3_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      rsp_q       <= rsp_nxt;
      psel_q      <= psel_nxt;
      penable_q   <= penable_nxt;
      rsp_valid_q <= rsp_valid_nxt;
`ifdef APB3_MASTER_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.m_apb3_pready || tmo_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_nxt       = req_q;
    rsp_nxt       = rsp_q;
    psel_nxt      = psel_q;
    penable_nxt   = penable_q;
    rsp_valid_nxt = rsp_valid_q;
`ifdef APB3_MASTER_TIMEOUT_EN
    tmo_cnt_nxt   = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          req_nxt.addr  = bus.cmd_addr;
          req_nxt.write = bus.cmd_write;
          req_nxt.wdata = bus.cmd_wdata;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
`ifdef APB3_MASTER_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
      end
      ACCESS: begin
        if (bus.m_apb3_pready) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_nxt.rdata   = req_q.write ? '0 : bus.m_apb3_prdata;
          rsp_nxt.err     = bus.m_apb3_pslverror;
          rsp_nxt.timeout = 1'b0;
          rsp_valid_nxt   = 1'b1;
        end else if (tmo_hit) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_nxt.rdata   = '0;
          rsp_nxt.err     = 1'b1;
          rsp_nxt.timeout = 1'b1;
          rsp_valid_nxt   = 1'b1;
        end else begin
`ifdef APB3_MASTER_TIMEOUT_EN
          tmo_cnt_nxt = tmo_cnt + TW'(1);
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Only unregistered output: gated by rstn so nothing is offered while reset is held.
  assign bus.cmd_ready       = (state == IDLE) && rstn;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_q.rdata;
  assign bus.rsp_err         = rsp_q.err;
  assign bus.rsp_timeout     = rsp_q.timeout;
  assign bus.m_apb3_paddr    = req_q.addr;
  assign bus.m_apb3_psel     = psel_q;
  assign bus.m_apb3_penable  = penable_q;
  assign bus.m_apb3_pwrite   = req_q.write;
  assign bus.m_apb3_pwdata   = req_q.wdata;

endmodule

// File: tb/tb_apb3_master.sv
// Directed bench for apb3_master: reset, zero-wait write, wait-state read, slverr with
// response backpressure, timeout (either build), reset mid-transfer, back-to-back throughput.
module tb_apb3_master;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  apb3_master_if #(.AW(20), .DW(32)) bus ();

  apb3_master #(.APB_AW(20), .APB_DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic wr, input logic [19:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'hABCDE;
    bus.cmd_wdata = 32'h11111111;
    tick();
    tick();
    n_cmp++;
    if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.m_apb3_pwrite, bus.rsp_valid, bus.rsp_err,
         bus.rsp_timeout, bus.cmd_ready} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: got psel=%b pen=%b pwr=%b rv=%b err=%b tmo=%b crdy=%b want all 0",
               bus.m_apb3_psel, bus.m_apb3_penable, bus.m_apb3_pwrite, bus.rsp_valid,
               bus.rsp_err, bus.rsp_timeout, bus.cmd_ready);
    end
    n_cmp++;
    if ({bus.m_apb3_paddr, bus.m_apb3_pwdata, bus.rsp_rdata} !== 84'h0) begin
      n_err++;
      $display("FAIL rst_data: got paddr=%h pwdata=%h rdata=%h want 0",
               bus.m_apb3_paddr, bus.m_apb3_pwdata, bus.rsp_rdata);
    end
    bus.cmd_valid = 1'b0;
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_rdy: got %b want 1", bus.cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.m_apb3_psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL rst_idle[%0d]: got psel=%b rv=%b crdy=%b want 0 0 1",
                 i, bus.m_apb3_psel, bus.rsp_valid, bus.cmd_ready);
      end
    end
  endtask

  task automatic test_write_zero_wait();
    bus.m_apb3_pready    = 1'b1;
    bus.m_apb3_prdata    = 32'hAAAA5555;
    bus.m_apb3_pslverror = 1'b0;
    bus.rsp_ready        = 1'b1;
    start_cmd(1'b1, 20'h00404, 32'hDEADBEEF);
    n_cmp++;
    if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.cmd_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL wr_setup: got psel=%b pen=%b crdy=%b want 1 0 0",
               bus.m_apb3_psel, bus.m_apb3_penable, bus.cmd_ready);
    end
    n_cmp++;
    if ({bus.m_apb3_paddr, bus.m_apb3_pwrite, bus.m_apb3_pwdata} !== {20'h00404, 1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_bus: got paddr=%h pwr=%b pwdata=%h want 00404 1 deadbeef",
               bus.m_apb3_paddr, bus.m_apb3_pwrite, bus.m_apb3_pwdata);
    end
    tick();
    n_cmp++;
    if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.m_apb3_paddr, bus.m_apb3_pwdata}
        !== {3'b110, 20'h00404, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_access: got psel=%b pen=%b rv=%b paddr=%h pwdata=%h",
               bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.m_apb3_paddr, bus.m_apb3_pwdata);
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.m_apb3_psel, bus.m_apb3_penable}
        !== {1'b1, 32'h0, 4'b0000}) begin
      n_err++;
      $display("FAIL wr_rsp: got rv=%b rdata=%h err=%b tmo=%b psel=%b pen=%b want 1 0 0 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
               bus.m_apb3_psel, bus.m_apb3_penable);
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.m_apb3_paddr, bus.m_apb3_pwdata}
        !== {2'b01, 20'h00404, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_done_hold: got rv=%b crdy=%b paddr=%h pwdata=%h want 0 1 00404 deadbeef",
               bus.rsp_valid, bus.cmd_ready, bus.m_apb3_paddr, bus.m_apb3_pwdata);
    end
  endtask

  task automatic test_read_wait();
    bus.m_apb3_pready = 1'b0;
    bus.m_apb3_prdata = 32'hBAD0BAD0;
    bus.rsp_ready     = 1'b1;
    start_cmd(1'b0, 20'h00100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.m_apb3_pwrite} !== 4'b1100) begin
        n_err++;
        $display("FAIL rd_wait[%0d]: got psel=%b pen=%b rv=%b pwr=%b want 1 1 0 0",
                 i, bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.m_apb3_pwrite);
      end
    end
    bus.m_apb3_pready = 1'b1;
    bus.m_apb3_prdata = 32'h12345678;
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.m_apb3_penable} !== {1'b1, 32'h12345678, 2'b00}) begin
      n_err++;
      $display("FAIL rd_rsp: got rv=%b rdata=%h err=%b pen=%b want 1 12345678 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.m_apb3_penable);
    end
    tick();
  endtask

  task automatic test_slverr_backpressure();
    bus.m_apb3_pready    = 1'b1;
    bus.m_apb3_prdata    = 32'hCAFEF00D;
    bus.m_apb3_pslverror = 1'b1;
    bus.rsp_ready        = 1'b0;
    start_cmd(1'b0, 20'h00200, 32'h0);
    tick();
    tick();
    bus.m_apb3_pslverror = 1'b0;
    bus.m_apb3_prdata    = 32'h0;
    bus.cmd_valid        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready, bus.m_apb3_psel}
          !== {1'b1, 32'hCAFEF00D, 3'b100}) begin
        n_err++;
        $display("FAIL err_hold[%0d]: got rv=%b rdata=%h err=%b crdy=%b psel=%b want 1 cafef00d 1 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready, bus.m_apb3_psel);
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.m_apb3_psel} !== 3'b010) begin
      n_err++;
      $display("FAIL err_release: got rv=%b crdy=%b psel=%b want 0 1 0",
               bus.rsp_valid, bus.cmd_ready, bus.m_apb3_psel);
    end
  endtask

  task automatic test_timeout();
    bus.m_apb3_pready    = 1'b0;
    bus.m_apb3_pslverror = 1'b0;
    bus.m_apb3_prdata    = 32'h55AA55AA;
    bus.rsp_ready        = 1'b1;
    start_cmd(1'b0, 20'h00300, 32'h0);
`ifdef APB3_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.m_apb3_penable, bus.rsp_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL tmo_wait[%0d]: got pen=%b rv=%b want 1 0", i, bus.m_apb3_penable, bus.rsp_valid);
      end
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.m_apb3_psel, bus.m_apb3_penable}
        !== {3'b111, 32'h0, 2'b00}) begin
      n_err++;
      $display("FAIL tmo_abort: got rv=%b err=%b tmo=%b rdata=%h psel=%b pen=%b want 1 1 1 0 0 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata,
               bus.m_apb3_psel, bus.m_apb3_penable);
    end
    tick();
    start_cmd(1'b0, 20'h00304, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    bus.m_apb3_pready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {3'b100, 32'h55AA55AA}) begin
      n_err++;
      $display("FAIL tmo_edge_win: got rv=%b err=%b tmo=%b rdata=%h want 1 0 0 55aa55aa",
               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
    end
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.rsp_timeout} !== 4'b1100) begin
      n_err++;
      $display("FAIL notmo_wait: got psel=%b pen=%b rv=%b tmo=%b want 1 1 0 0",
               bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.rsp_timeout);
    end
    bus.m_apb3_pready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {3'b100, 32'h55AA55AA}) begin
      n_err++;
      $display("FAIL notmo_done: got rv=%b err=%b tmo=%b rdata=%h want 1 0 0 55aa55aa",
               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    bus.m_apb3_pready = 1'b0;
    bus.rsp_ready     = 1'b1;
    start_cmd(1'b1, 20'h00500, 32'h0BADF00D);
    tick();
    rstn = 1'b0;
    tick();
    n_cmp++;
    if ({bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_rst: got psel=%b pen=%b rv=%b crdy=%b want 0 0 0 0",
               bus.m_apb3_psel, bus.m_apb3_penable, bus.rsp_valid, bus.cmd_ready);
    end
    rstn = 1'b1;
    bus.m_apb3_pready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.m_apb3_psel, bus.cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL mid_rst_quiet: got rv=%b psel=%b crdy=%b want 0 0 1",
               bus.rsp_valid, bus.m_apb3_psel, bus.cmd_ready);
    end
    bus.m_apb3_prdata = 32'h600DCAFE;
    start_cmd(1'b0, 20'h00600, 32'h0);
    tick();
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.m_apb3_paddr} !== {1'b1, 32'h600DCAFE, 1'b0, 20'h00600}) begin
      n_err++;
      $display("FAIL mid_rst_next: got rv=%b rdata=%h err=%b paddr=%h want 1 600dcafe 0 00600",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.m_apb3_paddr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc;
    int rsp;
    acc = 0;
    rsp = 0;
    bus.m_apb3_pready = 1'b1;
    bus.rsp_ready     = 1'b1;
    bus.cmd_valid     = 1'b1;
    bus.cmd_write     = 1'b1;
    bus.cmd_addr      = 20'h00700;
    bus.cmd_wdata     = 32'h77777777;
    for (int i = 0; i < 12; i++) begin
      if (bus.cmd_valid && bus.cmd_ready) acc++;
      if (bus.rsp_valid && bus.rsp_ready) rsp++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (acc !== 3 || rsp !== 3) begin
      n_err++;
      $display("FAIL b2b_rate: got accepts=%0d responses=%0d want 3 3", acc, rsp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.cmd_valid        = 1'b0;
    bus.cmd_write        = 1'b0;
    bus.cmd_addr         = '0;
    bus.cmd_wdata        = '0;
    bus.rsp_ready        = 1'b0;
    bus.m_apb3_pready    = 1'b0;
    bus.m_apb3_prdata    = '0;
    bus.m_apb3_pslverror = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
